// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcodes,
// mux-select encodings and the per-state strobe decode.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        HALT   = 4'd12,
        ERROR  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch marks the state whose IRWrite/PCWrite follow memReady directly.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       fetch;
        logic       memToReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       halted;
    } ctrl_t;

    function automatic logic isMemState(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    function automatic ctrl_t decodeState(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch    = 1'b1;
                c.memRead  = 1'b1;
                c.iorD     = 1'b0;
                c.aluSrcA  = 1'b0;
                c.aluSrcB  = SRCB_FOUR;
                c.aluOp    = ALUOP_ADD;
                c.pcSource = PCSRC_ALU;
            end
            DECODE: begin
                c.aluSrcA = 1'b0;
                c.aluSrcB = SRCB_IMMSH;
                c.aluOp   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALUOP_ADD;
            end
            MEMRD: begin
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            MEMWB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
                c.regDst   = 1'b0;
            end
            MEMWR: begin
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_RT;
                c.aluOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
                c.memToReg = 1'b0;
            end
            BRANCH: begin
                c.aluSrcA     = 1'b1;
                c.aluSrcB     = SRCB_RT;
                c.aluOp       = ALUOP_SUB;
                c.pcWriteCond = 1'b1;
                c.pcSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = PCSRC_JUMP;
            end
            ADDIWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b0;
                c.memToReg = 1'b0;
            end
            HALT: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Saturating 5-bit wait counter for memory states; flags the last permitted
// stall cycle before a bus timeout.
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    logic [4:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= 5'd0;
        end else if (inc && (count != 5'h1F)) begin
            count <= count + 5'd1;
        end
    end

    // A limit the 5-bit counter cannot reach behaves like "no timeout".
    generate
        if (TIMEOUT_CYCLES <= 0 || TIMEOUT_CYCLES > 32) begin : gNoTimeout
            assign expired = 1'b0;
        end else begin : gTimeout
            localparam logic [4:0] LIMIT = 5'(TIMEOUT_CYCLES - 1);
            assign expired = (count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle MIPS datapath with a shared instruction/data
// memory, memory-ready timeout, halt at instruction boundaries and sticky errors.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       memReady,
    input  logic       haltReq,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       halted,
    output logic       busError,
    output logic       illegalOp,
    output logic [3:0] state
);

    // Memory handshake: memRead/memWrite act as valid and are held, with IorD,
    // unchanged while memReady (ready) is low; a transfer completes on the edge
    // where both are high, and the FSM leaves the memory state on that edge.

    state_t stateQ;
    state_t stateNext;
    ctrl_t  ctrlQ;
    logic   busErrorQ;
    logic   illegalOpQ;
    logic   setBusError;
    logic   setIllegal;
    logic   inMemState;
    logic   waitExpired;
    logic   timeoutHit;
    state_t boundaryNext;

    assign inMemState   = isMemState(stateQ);
    assign timeoutHit   = inMemState && !memReady && waitExpired;
    assign boundaryNext = haltReq ? HALT : FETCH;

    mc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWaitTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!inMemState || memReady),
        .inc     (inMemState && !memReady),
        .expired (waitExpired)
    );

    always_comb begin
        stateNext   = stateQ;
        setBusError = 1'b0;
        setIllegal  = 1'b0;
        case (stateQ)
            FETCH: begin
                if (memReady) begin
                    stateNext = DECODE;
                end else if (timeoutHit) begin
                    stateNext   = ERROR;
                    setBusError = 1'b1;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_RTYPE:     stateNext = EXEC;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_J:         stateNext = JUMP;
                    OP_ADDI:      stateNext = ADDIEX;
                    default: begin
                        stateNext  = ERROR;
                        setIllegal = 1'b1;
                    end
                endcase
            end
            MEMADR: stateNext = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD: begin
                if (memReady) begin
                    stateNext = MEMWB;
                end else if (timeoutHit) begin
                    stateNext   = ERROR;
                    setBusError = 1'b1;
                end
            end
            MEMWR: begin
                if (memReady) begin
                    stateNext = boundaryNext;
                end else if (timeoutHit) begin
                    stateNext   = ERROR;
                    setBusError = 1'b1;
                end
            end
            EXEC:   stateNext = ALUWB;
            ADDIEX: stateNext = ADDIWB;
            MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: stateNext = boundaryNext;
            HALT:   stateNext = haltReq ? HALT : FETCH;
            ERROR:  stateNext = ERROR;
            default: stateNext = ERROR;
        endcase
    end

    // Strobes are registered from the next state so they line up with stateQ.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ     <= FETCH;
            ctrlQ      <= decodeState(FETCH);
            busErrorQ  <= 1'b0;
            illegalOpQ <= 1'b0;
        end else begin
            stateQ     <= stateNext;
            ctrlQ      <= decodeState(stateNext);
            busErrorQ  <= busErrorQ | setBusError;
            illegalOpQ <= illegalOpQ | setIllegal;
        end
    end

    // Holding reset drops any in-flight request immediately.
    assign PCWrite     = reset_n & (ctrlQ.pcWrite | (ctrlQ.fetch & memReady));
    assign IRWrite     = reset_n & ctrlQ.fetch & memReady;
    assign PCWriteCond = reset_n & ctrlQ.pcWriteCond;
    assign IorD        = reset_n & ctrlQ.iorD;
    assign memRead     = reset_n & ctrlQ.memRead;
    assign memWrite    = reset_n & ctrlQ.memWrite;
    assign memToReg    = reset_n & ctrlQ.memToReg;
    assign regDst      = reset_n & ctrlQ.regDst;
    assign regWrite    = reset_n & ctrlQ.regWrite;
    assign aluSrcA     = reset_n & ctrlQ.aluSrcA;
    assign aluSrcB     = reset_n ? ctrlQ.aluSrcB  : 2'b00;
    assign aluOp       = reset_n ? ctrlQ.aluOp    : 2'b00;
    assign pcSource    = reset_n ? ctrlQ.pcSource : 2'b00;
    assign halted      = reset_n & ctrlQ.halted;
    assign busError    = reset_n & busErrorQ;
    assign illegalOp   = reset_n & illegalOpQ;
    assign state       = reset_n ? stateQ : 4'd0;

endmodule
